partoserial_tx: RTL and testbench



---
 rtl/partoserial_tx_if.sv | 19 +
 rtl/partoserial_tx.sv | 90 +++++++++
 tb/tb_partoserial_tx.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/partoserial_tx_if.sv
// Byte-wide valid/ready handshake feeding the serial transmitter.
// The producer drives data_in/valid_in; the transmitter answers with ready_out.
interface partoserial_tx_if;
   logic [7:0] data_in;
   logic       valid_in;
   logic       ready_out;

   modport master (
      output data_in,
      output valid_in,
      input  ready_out
   );

   modport slave (
      input  data_in,
      input  valid_in,
      output ready_out
   );
endinterface

// File: rtl/partoserial_tx.sv
// Byte-to-serial transmitter: 2-deep byte buffer, MSB-first shift-out,
// 0xBC comma fill, and a fixed comma training run after reset.
module partoserial_tx #(
   parameter int unsigned TRAIN_BYTES = 8
) (
   input  logic             clk,
   input  logic             reset,
   partoserial_tx_if.slave  bus,
   output logic             data_out,
   output logic             sym_start,
   output logic             active,
   output logic             err_bc
);

   localparam logic [7:0] COMMA = 8'hBC;

   typedef enum logic {TRAIN, RUN} state_t;

   state_t     state;
   logic [7:0] shreg;
   logic [2:0] bit_cnt;
   logic [7:0] train_cnt;
   logic [7:0] fifo_mem [2];
   logic       rd_ptr;
   logic       wr_ptr;
   logic [1:0] count;
   logic       err_q;

   logic push;
   logic pop;
   logic boundary;
   logic last_comma;
   logic run_load;

   assign boundary   = (bit_cnt == 3'd7);
   assign push       = bus.valid_in && bus.ready_out;
   // The boundary closing the final comma already loads payload.
   assign last_comma = (state == TRAIN) && boundary &&
                       (train_cnt == 8'(TRAIN_BYTES - 1));
   assign run_load   = (state == RUN) || last_comma;
   assign pop        = boundary && run_load && (count != 2'd0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= TRAIN;
         shreg     <= COMMA;
         bit_cnt   <= 3'd0;
         train_cnt <= 8'd0;
         rd_ptr    <= 1'b0;
         wr_ptr    <= 1'b0;
         count     <= 2'd0;
         err_q     <= 1'b0;
      end else begin
         if (boundary) begin
            bit_cnt <= 3'd0;
            shreg   <= pop ? fifo_mem[rd_ptr] : COMMA;
            if (state == TRAIN) begin
               train_cnt <= train_cnt + 8'd1;
               if (last_comma)
                  state <= RUN;
            end
         end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg   <= {shreg[6:0], 1'b0};
         end

         if (push) begin
            fifo_mem[wr_ptr] <= bus.data_in;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;

         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase

         err_q <= push && (bus.data_in == COMMA);
      end
   end

   assign bus.ready_out = (count != 2'd2);
   assign data_out      = shreg[7];
   assign sym_start     = (bit_cnt == 3'd0);
   assign active        = (state == RUN);
   assign err_bc        = err_q;

endmodule

// File: tb/tb_partoserial_tx.sv
// Randomised scoreboard bench for partoserial_tx against a cycle-indexed
// slot model of the serial stream.
module tb_partoserial_tx;

   localparam int N = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic data_out, sym_start, active, err_bc;

   partoserial_tx_if bus ();

   partoserial_tx #(.TRAIN_BYTES(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .data_out  (data_out),
      .sym_start (sym_start),
      .active    (active),
      .err_bc    (err_bc)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [7:0] pend [$];
   logic [7:0] exp_q [$];
   logic [7:0] cur = 8'hBC;
   int         cyc = 0;
   logic       err_exp = 1'b0;
   logic       last_acc = 1'b0;

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Slot model: cycle index since reset decides framing and training.
   always @(posedge clk) begin
      logic acc;
      if (reset) begin
         pend.delete();
         exp_q.delete();
         exp_q.push_back(8'hBC);
         cur      = 8'hBC;
         cyc      = 0;
         err_exp  = 1'b0;
         last_acc = 1'b0;
      end else begin
         acc = bus.valid_in && (pend.size() < 2);
         if (cyc % 8 == 7) begin
            if ((cyc + 1 >= 8 * N) && (pend.size() > 0))
               cur = pend.pop_front();
            else
               cur = 8'hBC;
            exp_q.push_back(cur);
         end
         if (acc)
            pend.push_back(bus.data_in);
         err_exp  = acc && (bus.data_in == 8'hBC);
         last_acc = acc;
         cyc++;
      end
   end

   logic [7:0] asm_byte = 8'h00;
   int         nbits = 0;

   always @(negedge clk) begin
      int bi;
      if (reset) begin
         nbits    = 0;
         asm_byte = 8'h00;
      end else begin
         bi = 7 - (cyc % 8);
         check("data_out", int'(data_out), int'(cur[bi]));
         check("sym_start", int'(sym_start), int'(cyc % 8 == 0));
         check("active", int'(active), int'(cyc >= 8 * N));
         check("ready_out", int'(bus.ready_out), int'(pend.size() < 2));
         check("err_bc", int'(err_bc), int'(err_exp));
         asm_byte = {asm_byte[6:0], data_out};
         nbits++;
         if (nbits == 8) begin
            nbits = 0;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL slot: got %02h but no slot expected", asm_byte);
            end else begin
               check("slot", int'(asm_byte), int'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      bus.valid_in = 1'b0;
      repeat (n) step();
   endtask

   task automatic do_reset(input int n);
      bus.valid_in = 1'b0;
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input int bound);
      bus.valid_in = 1'b1;
      bus.data_in  = b;
      for (int i = 0; i < bound; i++) begin
         step();
         if (last_acc) return;
      end
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %02h not accepted in %0d cycles, expected accept", b, bound);
   endtask

   task automatic wait_cyc(input int target);
      for (int i = 0; i < 400 && cyc < target; i++) step();
      check("reach_cycle", int'(cyc >= target), 1);
   endtask

   initial begin
      bus.valid_in = 1'b0;
      bus.data_in  = 8'h00;

      // training run, then a single payload byte at cycle 70
      do_reset(2);
      wait_cyc(70);
      send(8'h5A, 4);
      idle(30);

      // three pushes during training, third held off
      do_reset(2);
      send(8'h11, 4);
      send(8'h22, 4);
      send(8'h33, 200);
      bus.valid_in = 1'b0;
      wait_cyc(100);

      // back-to-back payload
      for (int i = 0; i < 16; i++) send(8'(i), 64);
      idle(40);

      // comma-valued payload
      send(8'hBC, 16);
      idle(20);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         bus.valid_in = ($urandom_range(0, 2) == 0);
         bus.data_in  = ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom);
         step();
      end
      idle(30);

      // reset mid-payload with the buffer full
      send(8'hA1, 32);
      send(8'hA2, 32);
      send(8'hA3, 32);
      send(8'hA4, 32);
      bus.valid_in = 1'b0;
      for (int i = 0; i < 16 && (cyc % 8 != 4); i++) step();
      check("bit4_reached", cyc % 8, 4);
      check("full_before_reset", int'(bus.ready_out), 0);
      do_reset(1);
      check("post_reset_data", int'(data_out), 1);
      check("post_reset_sym", int'(sym_start), 1);
      check("post_reset_ready", int'(bus.ready_out), 1);
      check("post_reset_active", int'(active), 0);
      idle(8 * N + 40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
